// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl
// Coefficient configuration controller for the 64-tap equalizer FIR.
// The host fills a shadow bank through a valid/ready write port. A commit
// request arms a swap, and the swap copies the whole shadow bank into the
// active bank on the next audio sample boundary. The FIR therefore never
// sees a mixed coefficient set. The active bank is a plain register that
// drives gain_flat_o directly.
//
// Optional feature, enabled by defining FIR_COEFF_CLEAR_EN:
//   adds the clear_req_i input and a CLEAR state that zeroes the shadow
//   bank one entry per cycle. The active bank is left untouched.

module fir_coeff_ctrl #(
    parameter int N  = 64,
    parameter int CW = 32,
    parameter int AW = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sample_tick_i,
    input  logic            wr_valid_i,
    output logic            wr_ready_o,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [CW-1:0]   wr_data_i,
    input  logic            commit_req_i,
`ifdef FIR_COEFF_CLEAR_EN
    input  logic            clear_req_i,
`endif
    output logic            commit_ack_o,
    output logic            busy_o,
    output logic [7:0]      bank_gen_o,
    output logic [N*CW-1:0] gain_flat_o
);

    // Controller states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
`ifdef FIR_COEFF_CLEAR_EN
    localparam logic [1:0] ST_CLEAR   = 2'd2;
`endif

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [N*CW-1:0] shadow_q;
    logic [N*CW-1:0] shadow_d;
    logic [N*CW-1:0] active_q;
    logic [N*CW-1:0] active_d;
    logic [7:0]      bankGen_q;
    logic [7:0]      bankGen_d;
    logic            commitAck_q;
    logic            commitAck_d;
    logic            wrFire;
    logic            swapNow;
`ifdef FIR_COEFF_CLEAR_EN
    logic [AW-1:0]   clrCnt_q;
    logic [AW-1:0]   clrCnt_d;
`endif

    // Writes are only accepted while idle; PENDING and CLEAR freeze the port
    assign wr_ready_o   = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign wrFire       = wr_valid_i && wr_ready_o;
    assign swapNow      = (state_q == ST_PENDING) && sample_tick_i;
    assign commit_ack_o = commitAck_q;
    assign bank_gen_o   = bankGen_q;
    assign gain_flat_o  = active_q;

    // Next-state logic: a clear outranks a commit, and a swap waits for a tick seen while PENDING
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef FIR_COEFF_CLEAR_EN
                if (clear_req_i) begin
                    state_d = ST_CLEAR;
                end else if (commit_req_i) begin
                    state_d = ST_PENDING;
                end
`else
                if (commit_req_i) begin
                    state_d = ST_PENDING;
                end
`endif
            end
            ST_PENDING: begin
                if (sample_tick_i) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef FIR_COEFF_CLEAR_EN
            ST_CLEAR: begin
                if (int'(clrCnt_q) == N - 1) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef FIR_COEFF_CLEAR_EN
    // Clear sweep counter: walks 0..N-1 while clearing and rests at zero otherwise
    always_comb begin
        clrCnt_d = '0;
        if (state_q == ST_CLEAR && int'(clrCnt_q) != N - 1) begin
            clrCnt_d = clrCnt_q + AW'(1);
        end
    end
`endif

    // Shadow bank update: the host write lands on its entry, and addresses past N match nothing
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < N; i++) begin
            if (wrFire && int'(wr_addr_i) == i) begin
                shadow_d[i*CW +: CW] = wr_data_i;
            end
`ifdef FIR_COEFF_CLEAR_EN
            if (state_q == ST_CLEAR && int'(clrCnt_q) == i) begin
                shadow_d[i*CW +: CW] = '0;
            end
`endif
        end
    end

    // Swap path: copy every entry in one edge, bump the generation count and raise the ack
    always_comb begin
        active_d    = active_q;
        bankGen_d   = bankGen_q;
        commitAck_d = 1'b0;
        if (swapNow) begin
            active_d    = shadow_q;
            bankGen_d   = bankGen_q + 8'd1;
            commitAck_d = 1'b1;
        end
    end

    // State registers: asynchronous reset discards both banks and any pending commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            bankGen_q   <= '0;
            commitAck_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            bankGen_q   <= bankGen_d;
            commitAck_q <= commitAck_d;
        end
    end

`ifdef FIR_COEFF_CLEAR_EN
    // Clear counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clrCnt_q <= '0;
        end else begin
            clrCnt_q <= clrCnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// tb_fir_coeff_ctrl
// Directed bench for fir_coeff_ctrl. Expected values are hand-computed
// constants. When FIR_COEFF_CLEAR_EN is defined, the CLEAR sequence is
// exercised as well.

module tb_fir_coeff_ctrl;

    localparam int N  = 64;
    localparam int CW = 32;
    localparam int AW = 6;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            sample_tick_i;
    logic            wr_valid_i;
    logic            wr_ready_o;
    logic [AW-1:0]   wr_addr_i;
    logic [CW-1:0]   wr_data_i;
    logic            commit_req_i;
`ifdef FIR_COEFF_CLEAR_EN
    logic            clear_req_i;
`endif
    logic            commit_ack_o;
    logic            busy_o;
    logic [7:0]      bank_gen_o;
    logic [N*CW-1:0] gain_flat_o;

    int testsRun    = 0;
    int testsFailed = 0;
    int ackCount    = 0;

    fir_coeff_ctrl #(.N(N), .CW(CW), .AW(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_tick_i(sample_tick_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .commit_req_i (commit_req_i),
`ifdef FIR_COEFF_CLEAR_EN
        .clear_req_i  (clear_req_i),
`endif
        .commit_ack_o (commit_ack_o),
        .busy_o       (busy_o),
        .bank_gen_o   (bank_gen_o),
        .gain_flat_o  (gain_flat_o)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    // Count commit_ack pulses on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (commit_ack_o === 1'b1) ackCount++;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] entry(input int i);
        return gain_flat_o[i*CW +: CW];
    endfunction

    function automatic logic [31:0] anyGain();
        return {31'b0, |gain_flat_o};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then move to 1 time unit after the next rising edge
    task automatic applyStimulus(input logic v, input int a, input logic [31:0] d,
                                 input logic c, input logic s);
        wr_valid_i    = v;
        wr_addr_i     = AW'(a);
        wr_data_i     = d;
        commit_req_i  = c;
        sample_tick_i = s;
        @(posedge clk);
        #1;
    endtask

    task automatic doCommit();
        applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n       = 1'b0;
        sample_tick_i = 1'b0;
        wr_valid_i    = 1'b0;
        wr_addr_i     = '0;
        wr_data_i     = '0;
        commit_req_i  = 1'b0;
`ifdef FIR_COEFF_CLEAR_EN
        clear_req_i   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        checkOutput("reset_gain",     anyGain(), 32'd0);
        checkOutput("reset_bank_gen", 32'(bank_gen_o), 32'd0);
        checkOutput("reset_wr_ready", 32'(wr_ready_o), 32'd1);
        checkOutput("reset_busy",     32'(busy_o), 32'd0);
        checkOutput("reset_ack",      32'(commit_ack_o), 32'd0);
        repeat (3) applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b0);
        checkOutput("idle_ack_count", 32'(ackCount), 32'd0);

        // Basic write and commit, with the sample tick arriving 5 cycles later
        applyStimulus(1'b1, 0,  32'h0000_4000, 1'b0, 1'b0);
        applyStimulus(1'b1, 63, 32'hFFFF_C000, 1'b0, 1'b0);
        applyStimulus(1'b0, 0,  32'h0, 1'b1, 1'b0);
        checkOutput("pend_busy",     32'(busy_o), 32'd1);
        checkOutput("pend_wr_ready", 32'(wr_ready_o), 32'd0);
        checkOutput("pend_entry0",   entry(0), 32'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b0);
            checkOutput("wait_entry0",  entry(0), 32'h0);
            checkOutput("wait_entry63", entry(63), 32'h0);
            checkOutput("wait_ack",     32'(commit_ack_o), 32'd0);
        end
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b1);
        checkOutput("swap1_ack",      32'(commit_ack_o), 32'd1);
        checkOutput("swap1_entry0",   entry(0), 32'h0000_4000);
        checkOutput("swap1_entry63",  entry(63), 32'hFFFF_C000);
        checkOutput("swap1_bank_gen", 32'(bank_gen_o), 32'd1);
        checkOutput("swap1_busy",     32'(busy_o), 32'd0);
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b0);
        checkOutput("swap1_ack_drop", 32'(commit_ack_o), 32'd0);
        checkOutput("swap1_ack_cnt",  32'(ackCount), 32'd1);

        // Write held during PENDING stalls until the first IDLE cycle
        applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 5, 32'h55, 1'b0, 1'b0);
        checkOutput("stall_ready_a", 32'(wr_ready_o), 32'd0);
        applyStimulus(1'b1, 5, 32'h55, 1'b0, 1'b0);
        checkOutput("stall_ready_b", 32'(wr_ready_o), 32'd0);
        applyStimulus(1'b1, 5, 32'h55, 1'b0, 1'b1);
        checkOutput("stall_ack",      32'(commit_ack_o), 32'd1);
        checkOutput("stall_entry5",   entry(5), 32'h0);
        checkOutput("stall_bank_gen", 32'(bank_gen_o), 32'd2);
        checkOutput("stall_ready_c",  32'(wr_ready_o), 32'd1);
        applyStimulus(1'b1, 5, 32'h55, 1'b0, 1'b0);

        // commit_req, sample_tick and a write all in one IDLE cycle
        applyStimulus(1'b1, 10, 32'h7, 1'b1, 1'b1);
        checkOutput("same_ack",      32'(commit_ack_o), 32'd0);
        checkOutput("same_busy",     32'(busy_o), 32'd1);
        checkOutput("same_bank_gen", 32'(bank_gen_o), 32'd2);
        checkOutput("same_entry10",  entry(10), 32'h0);
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b0);
        checkOutput("same_busy_hold", 32'(busy_o), 32'd1);
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b1);
        checkOutput("swap3_ack",      32'(commit_ack_o), 32'd1);
        checkOutput("swap3_entry10",  entry(10), 32'h7);
        checkOutput("swap3_entry5",   entry(5), 32'h55);
        checkOutput("swap3_entry0",   entry(0), 32'h0000_4000);
        checkOutput("swap3_bank_gen", 32'(bank_gen_o), 32'd3);
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b0);
        checkOutput("swap3_ack_cnt",  32'(ackCount), 32'd3);

        // Generation counter wraps 255 -> 0
        for (int k = 0; k < 252; k++) doCommit();
        checkOutput("gen_255", 32'(bank_gen_o), 32'd255);
        doCommit();
        checkOutput("gen_wrap",    32'(bank_gen_o), 32'd0);
        checkOutput("gen_ack_cnt", 32'(ackCount), 32'd256);
        checkOutput("gen_entry10", entry(10), 32'h7);
        doCommit();
        checkOutput("gen_one", 32'(bank_gen_o), 32'd1);

        // Reset in the middle of PENDING
        applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b0);
        checkOutput("rst_pend_busy", 32'(busy_o), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_gain",     anyGain(), 32'd0);
        checkOutput("rst_bank_gen", 32'(bank_gen_o), 32'd0);
        checkOutput("rst_busy",     32'(busy_o), 32'd0);
        sample_tick_i = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b0);
        checkOutput("rst_ack_cnt",  32'(ackCount), 32'd257);
        checkOutput("rst_bank_gen2", 32'(bank_gen_o), 32'd0);
        checkOutput("rst_gain2",    anyGain(), 32'd0);
        doCommit();
        checkOutput("rst_shadow_gain", anyGain(), 32'd0);
        checkOutput("rst_shadow_e10",  entry(10), 32'h0);
        checkOutput("rst_commit_gen",  32'(bank_gen_o), 32'd1);

`ifdef FIR_COEFF_CLEAR_EN
        // Clear sequence: load all ones, commit, then clear with a simultaneous commit
        begin
            int busyCycles;
            for (int i = 0; i < N; i++) applyStimulus(1'b1, i, 32'h1, 1'b0, 1'b0);
            applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b0);
            doCommit();
            checkOutput("clr_pre_e0",  entry(0), 32'h1);
            checkOutput("clr_pre_e63", entry(63), 32'h1);
            clear_req_i = 1'b1;
            applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b0);
            clear_req_i = 1'b0;
            busyCycles = 0;
            while (busy_o === 1'b1 && busyCycles < 100) begin
                busyCycles++;
                applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b1);
            end
            applyStimulus(1'b0, 0, 32'h0, 1'b0, 1'b0);
            checkOutput("clr_busy_cycles", 32'(busyCycles), 32'd64);
            checkOutput("clr_active_e0",   entry(0), 32'h1);
            checkOutput("clr_active_e37",  entry(37), 32'h1);
            checkOutput("clr_bank_gen",    32'(bank_gen_o), 32'd2);
            checkOutput("clr_ack_cnt",     32'(ackCount), 32'd259);
            doCommit();
            checkOutput("clr_commit_gain", anyGain(), 32'd0);
            checkOutput("clr_commit_gen",  32'(bank_gen_o), 32'd3);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fir_coeff_ctrl.md
Name: fir_coeff_ctrl

Overview:
Coefficient configuration controller for the 64-tap equalizer FIR.
- Host writes coefficients into a shadow bank through a valid/ready write port.
- On commit, the shadow bank is copied to the active bank, which drives the FIR gain inputs.
- The copy happens only on an audio sample boundary, so the filter never convolves with a mixed coefficient set.

Parameters:
N, 64, number of taps / coefficients per bank
CW, 32, coefficient width (signed)
AW, 6, address width; must satisfy 2**AW >= N

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
sample_tick  input  1  one-cycle pulse marking an audio sample boundary
wr_valid  input  1  host write request
wr_ready  output  1  controller can accept a write this cycle
wr_addr  input  AW  coefficient index
wr_data  input  CW  signed coefficient value
commit_req  input  1  one-cycle pulse: request shadow-to-active swap
commit_ack  output  1  one-cycle pulse: swap completed
busy  output  1  state != IDLE
bank_gen  output  8  count of completed swaps
gain_flat  output  N*CW  active bank; coefficient i at bits [i*CW +: CW]

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk. Reset is fully asynchronous.
- Reset values: shadow bank and active bank all zero, gain_flat=0, wr_ready=1, commit_ack=0, busy=0, bank_gen=0, state=IDLE.
- States: IDLE, PENDING, and CLEAR (CLEAR only with the optional feature).

IDLE:
- wr_ready=1.
- Write handshake: on wr_valid && wr_ready at a clock edge, shadow[wr_addr] <= wr_data.
- Writes with wr_addr >= N are accepted and discarded.
- commit_req=1 -> PENDING.
- Write and commit_req in the same cycle: the write lands in shadow and is included in the swap.

PENDING:
- wr_ready=0; writes are stalled, shadow is frozen.
- commit_req is ignored.
- On the first edge with sample_tick=1:
  - active <= shadow (all N entries at that same edge);
  - bank_gen += 1, wrapping 255 -> 0;
  - commit_ack=1 for exactly the following cycle;
  - state -> IDLE.
- sample_tick in the same IDLE cycle as commit_req does not trigger the swap. The swap waits for the next sample_tick after entering PENDING.

General:
- Latency: the swap occurs at the edge sampling sample_tick. gain_flat shows the new set from the cycle after that edge, concurrent with commit_ack.
- gain_flat is a direct register output (no combinational path from inputs). It changes only at a swap or at reset.
- sample_tick outside PENDING has no effect.
- Reset asserted mid-PENDING (or mid-CLEAR): both banks zero, pending commit discarded, no commit_ack.
- Each shadow entry is written only in IDLE via the handshake, or in CLEAR.

Optional Feature:
Macro FIR_COEFF_CLEAR_EN.

Defined:
- Adds input port clear_req (1 bit, one-cycle pulse) and state CLEAR.
- In IDLE, clear_req=1 -> CLEAR.
- clear_req has priority over commit_req in the same cycle; that commit_req is dropped.
- A wr_valid handshake in the same cycle as clear_req still completes, and is then overwritten by the clear.
- CLEAR behaviour:
  - wr_ready=0, busy=1;
  - a counter cnt runs 0..N-1, writing shadow[cnt] <= 0, one entry per cycle;
  - after N cycles -> IDLE;
  - the active bank is untouched;
  - commit_req, clear_req and sample_tick are ignored during CLEAR.

Not defined:
- No clear_req port, no CLEAR state.
- Shadow is cleared only by reset.

Test Plan:
- Reset then idle -> gain_flat=0, bank_gen=0, wr_ready=1, busy=0, commit_ack never asserted.
- Write addr 0 = 32'h0000_4000 and addr 63 = 32'hFFFF_C000, then commit_req, sample_tick 5 cycles later:
  - gain_flat unchanged for those 5 cycles;
  - then entry0 = 0x4000 and entry63 = 0xFFFFC000;
  - commit_ack is a one-cycle pulse; bank_gen=1.
- wr_valid held during PENDING -> wr_ready=0, no shadow change. Write completes in the first IDLE cycle after commit_ack.
- commit_req and sample_tick in the same cycle, plus a write to addr 10 = 7 in that cycle:
  - no swap then;
  - swap at the next sample_tick, with entry10 = 7.
- 256 commits -> bank_gen wraps to 0. reset_n pulsed while PENDING -> both banks 0, no commit_ack.
- With FIR_COEFF_CLEAR_EN, load shadow all 1, clear_req with simultaneous commit_req:
  - busy for exactly 64 cycles, commit dropped, active unchanged;
  - a following commit makes gain_flat all zero.
